// File: rtl/dmem_store_queue.sv
// Data-memory stage: stores retire into a circular queue that drains one word per
// cycle into a word RAM; loads forward from the youngest pending entry.
module dmem_store_queue #(
  parameter int DEPTH  = 64,
  parameter int QDEPTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      MemWrite,
  input  logic                      VecStore,
  input  logic [31:0]               ALUResult,
  input  logic [31:0]               WriteData,
  input  logic [31:0]               VecWriteData_0,
  input  logic [31:0]               VecWriteData_1,
  input  logic [31:0]               VecWriteData_2,
  input  logic [31:0]               VecWriteData_3,
  input  logic [31:0]               VecWriteData_4,
  output logic [31:0]               ReadData,
  output logic [$clog2(QDEPTH):0]   QueueCount,
  output logic                      QueueFull,
  output logic                      Overflow
);

  localparam int AW     = $clog2(DEPTH);
  localparam int QW     = $clog2(QDEPTH);
  localparam int VLANES = 5;

  logic [AW-1:0] q_idx  [QDEPTH];
  logic [31:0]   q_data [QDEPTH];
  logic [31:0]   mem    [DEPTH];

  logic [QW-1:0] head;
  logic [QW-1:0] tail;
  logic [QW:0]   count;
  logic          overflow_q;

  logic [AW-1:0] addr_w;
  logic [31:0]   lane_data [VLANES];
  logic          scalar_req;
  logic          vector_req;
  logic          scalar_ok;
  logic          vector_ok;
  logic          store_drop;
  logic          drain;
  logic [QW:0]   enq_n;
  int            free_slots;

  logic          fwd_hit;
  logic [31:0]   fwd_data;

  // Byte-offset and above-RAM address bits carry no meaning for a word RAM.
  logic          unused_addr_bits;
  assign unused_addr_bits = ^{ALUResult[31:AW+2], ALUResult[1:0]};

  assign addr_w = ALUResult[AW+1:2];

  assign lane_data[0] = VecWriteData_0;
  assign lane_data[1] = VecWriteData_1;
  assign lane_data[2] = VecWriteData_2;
  assign lane_data[3] = VecWriteData_3;
  assign lane_data[4] = VecWriteData_4;

  // Capacity is judged on the count before this edge's drain, so an entry that
  // leaves this cycle cannot make room for a store arriving in the same cycle.
  assign free_slots = QDEPTH - int'(count);
  assign scalar_req = MemWrite && !VecStore;
  assign vector_req = MemWrite && VecStore;
  assign scalar_ok  = scalar_req && (free_slots >= 1);
  assign vector_ok  = vector_req && (free_slots >= VLANES);
  assign store_drop = (scalar_req && !scalar_ok) || (vector_req && !vector_ok);
  assign drain      = (count != '0);
  assign enq_n      = vector_ok ? (QW+1)'(VLANES) : (QW+1)'(scalar_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (drain) begin
        head <= head + 1'b1;
      end
      tail  <= tail + enq_n[QW-1:0];
      count <= count + enq_n - (QW+1)'(drain);
      if (store_drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Entry storage needs no reset: only slots covered by count are ever read.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (scalar_ok) begin
        q_idx[tail]  <= addr_w;
        q_data[tail] <= WriteData;
      end else if (vector_ok) begin
        for (int k = 0; k < VLANES; k++) begin
          q_idx[tail + QW'(k)]  <= addr_w + AW'(k);
          q_data[tail + QW'(k)] <= lane_data[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (drain) begin
      mem[q_idx[head]] <= q_data[head];
    end
  end

  // Walk oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (((QW+1)'(i) < count) && (q_idx[head + QW'(i)] == addr_w)) begin
        fwd_hit  = 1'b1;
        fwd_data = q_data[head + QW'(i)];
      end
    end
  end

  assign ReadData   = fwd_hit ? fwd_data : mem[addr_w];
  assign QueueCount = count;
  assign QueueFull  = (free_slots < VLANES);
  assign Overflow   = overflow_q;

endmodule
